// File: rtl/cdb_arbiter.sv
// cdb_arbiter: schedules result broadcasts from NREQ producers (0 = ALU,
// 1 = load buffer, 2 = address unit) onto the common data bus. Each producer
// feeds a DEPTH-entry circular FIFO; one head entry per cycle is granted and
// broadcast as a registered {tag, result} pair. A ROB flush empties all FIFOs.
// Optional feature: define CDB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority, lowest index wins.
module cdb_arbiter #(
  parameter int NREQ   = 3,
  parameter int ROB_W  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   rob_flush_in,
  input  logic [NREQ-1:0]        req_valid_in,
  output logic [NREQ-1:0]        req_ready_out,
  input  logic [NREQ*ROB_W-1:0]  req_tag_in,
  input  logic [NREQ*DATA_W-1:0] req_data_in,
  output logic [ROB_W-1:0]       cdb_b_out,
  output logic [DATA_W-1:0]      cdb_result_out,
  output logic [1:0]             cdb_src_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ROB_W-1:0]  tag_mem_q  [NREQ][DEPTH];
  logic [DATA_W-1:0] data_mem_q [NREQ][DEPTH];

  logic [CW-1:0] rd_ptr_q [NREQ];
  logic [CW-1:0] rd_ptr_d [NREQ];
  logic [CW-1:0] wr_ptr_q [NREQ];
  logic [CW-1:0] wr_ptr_d [NREQ];
  logic [CW-1:0] count_q  [NREQ];
  logic [CW-1:0] count_d  [NREQ];

  logic [ROB_W-1:0]  cdb_b_q, cdb_b_d;
  logic [DATA_W-1:0] cdb_result_q, cdb_result_d;
  logic [1:0]        cdb_src_q, cdb_src_d;

  logic [NREQ-1:0] push, pop;
  logic            gnt_valid;
  logic [1:0]      gnt_idx;
  logic            active;

`ifdef CDB_ROUND_ROBIN_EN
  logic [1:0] rr_q, rr_d;
`endif

  function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
    return (p == CW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign active = rdy_in && !rob_flush_in;

  // Ready depends only on occupancy, never on the request valid.
  always_comb begin
    req_ready_out = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      req_ready_out[i] = (count_q[i] != CW'(DEPTH));
  end

  // Pick one non-empty FIFO from the occupancy held before the edge.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
`ifdef CDB_ROUND_ROBIN_EN
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 2'((32'(rr_q) + k) % NREQ);
      if (!gnt_valid && count_q[idx] != '0) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
`else
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_valid && count_q[k] != '0) begin
        gnt_valid = 1'b1;
        gnt_idx   = 2'(k);
      end
    end
`endif
  end

  // Handshake qualification: tag-0 requests complete the handshake but are dropped.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      push[i] = active && req_valid_in[i] && req_ready_out[i] &&
                (req_tag_in[i*ROB_W +: ROB_W] != '0);
      pop[i]  = active && gnt_valid && (gnt_idx == 2'(i));
    end
  end

  // FIFO pointer/count next state; flush clears everything and overrides push/pop.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      count_d[i]  = count_q[i];
      if (rdy_in && rob_flush_in) begin
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
        count_d[i]  = '0;
      end else begin
        if (push[i]) wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
        if (pop[i])  rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
        count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // Bus next state: tag clears when idle, result/source hold; all hold when rdy_in is low.
  always_comb begin
    cdb_b_d      = cdb_b_q;
    cdb_result_d = cdb_result_q;
    cdb_src_d    = cdb_src_q;
    if (rdy_in) begin
      cdb_b_d = '0;
      if (!rob_flush_in && gnt_valid) begin
        cdb_b_d      = tag_mem_q[gnt_idx][rd_ptr_q[gnt_idx][PW-1:0]];
        cdb_result_d = data_mem_q[gnt_idx][rd_ptr_q[gnt_idx][PW-1:0]];
        cdb_src_d    = gnt_idx;
      end
    end
  end

`ifdef CDB_ROUND_ROBIN_EN
  // Round-robin pointer: one past the last grant, cleared on flush.
  always_comb begin
    rr_d = rr_q;
    if (rdy_in) begin
      if (rob_flush_in)
        rr_d = '0;
      else if (gnt_valid)
        rr_d = (gnt_idx == 2'(NREQ - 1)) ? '0 : gnt_idx + 2'd1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) rr_q <= '0;
    else         rr_q <= rr_d;
  end
`endif

  // Control and bus registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      cdb_b_q      <= '0;
      cdb_result_q <= '0;
      cdb_src_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      cdb_b_q      <= cdb_b_d;
      cdb_result_q <= cdb_result_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  // FIFO storage writes; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_in) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (push[i]) begin
        tag_mem_q[i][wr_ptr_q[i][PW-1:0]]  <= req_tag_in[i*ROB_W +: ROB_W];
        data_mem_q[i][wr_ptr_q[i][PW-1:0]] <= req_data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cdb_b_out      = cdb_b_q;
  assign cdb_result_out = cdb_result_q;
  assign cdb_src_out    = cdb_src_q;

endmodule
